aes_encrypt_iter: RTL and testbench



---
 rtl/aes_encrypt_iter.sv | 150 +++++++++++++++
 tb/tb_aes_encrypt_iter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption engine: one round per clock over a shared round
// datapath, with round keys expanded on the fly from the captured cipher key.
module aes_encrypt_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic [127:0] dataout,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         fsm;
  logic [127:0] state_reg;
  logic [127:0] rkey_reg;
  logic [7:0]   rcon;
  logic [3:0]   round;

  logic [127:0] sb, sr, mc, next_key, round_out;
  logic [31:0]  w0, w1, w2, w3, temp;
  logic [31:0]  n0, n1, n2, n3;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Forward S-box computed as GF(2^8) inverse (a^254, so 0 maps to 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x3, x7, x15, x31, x63, x127, inv;
    x3   = gf_mul(gf_mul(a, a), a);
    x7   = gf_mul(gf_mul(x3, x3), a);
    x15  = gf_mul(gf_mul(x7, x7), a);
    x31  = gf_mul(gf_mul(x15, x15), a);
    x63  = gf_mul(gf_mul(x31, x31), a);
    x127 = gf_mul(gf_mul(x63, x63), a);
    inv  = gf_mul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  assign w0 = rkey_reg[127:96];
  assign w1 = rkey_reg[95:64];
  assign w2 = rkey_reg[63:32];
  assign w3 = rkey_reg[31:0];

  // SubWord(RotWord(w3)) with the round constant folded into the top byte
  assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^
                {rcon, 24'h000000};
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) begin
      sb[127-8*i -: 8] = sbox(state_reg[127-8*i -: 8]);
    end
    // Byte (r,c) sits at index r+4c; row r rotates left by r columns
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end
  end

  assign round_out = ((round == 4'd10) ? sr : mc) ^ next_key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      dataout   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      round     <= 4'd0;
      state_reg <= '0;
      rkey_reg  <= '0;
      rcon      <= 8'h00;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            state_reg <= datain ^ key;
            rkey_reg  <= key;
            rcon      <= 8'h01;
            round     <= 4'd1;
            busy      <= 1'b1;
            fsm       <= RUN;
          end
        end
        RUN: begin
          // Unreachable round values abandon the block silently
          if (round == 4'd0 || round > 4'd10) begin
            round <= 4'd0;
            busy  <= 1'b0;
            fsm   <= IDLE;
          end else begin
            state_reg <= round_out;
            rkey_reg  <= next_key;
            rcon      <= xtime(rcon);
            if (round == 4'd10) begin
              dataout <= round_out;
              done    <= 1'b1;
              busy    <= 1'b0;
              round   <= 4'd0;
              fsm     <= IDLE;
            end else begin
              round <= round + 4'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter: FIPS-197 vectors, latency, back-to-back
// starts, ignored mid-run starts and asynchronous reset during a block.
module tb_aes_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [127:0] datain = '0;
  logic [127:0] key = '0;
  logic [127:0] dataout;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_encrypt_iter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .datain  (datain),
    .key     (key),
    .dataout (dataout),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts one block at the current negedge and follows it to done.
  // glitch > 0 pulses start with other data at that sample, which must be ignored.
  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k,
                               input logic [127:0] exp, input string tag,
                               input bit check_rk1, input logic [127:0] exp_rk1,
                               input int glitch);
    int lat;
    int busy_cnt;
    lat = -1;
    busy_cnt = 0;
    start = 1'b1;
    datain = pt;
    key = k;
    @(negedge clk);
    start = 1'b0;
    datain = ~pt;
    key = ~k;
    for (int i = 0; i <= 20 && lat < 0; i++) begin
      if (i > 0) @(negedge clk);
      if (i == glitch) begin
        start = 1'b1;
        datain = 128'h0;
        key = 128'h0;
      end else if (glitch > 0 && i == glitch + 1) begin
        start = 1'b0;
      end
      if (check_rk1 && i == 1) checkOutput({tag, "_rk1"}, dut.rkey_reg, exp_rk1);
      if (done) lat = i;
      else if (busy) busy_cnt++;
    end
    start = 1'b0;
    checkOutput({tag, "_latency"}, lat, 10);
    checkOutput({tag, "_busy_cycles"}, busy_cnt, 10);
    checkOutput({tag, "_busy_at_done"}, busy, 1'b0);
    checkOutput({tag, "_dataout"}, dataout, exp);
  endtask

  initial begin
    int done_cnt, first_done, last_done, merged, dout_bad, extra_done;
    logic prev_done;
    logic [127:0] prev_dout;

    #2 rst_n = 1'b0;
    #2;
    checkOutput("reset_dataout", dataout, 128'h0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(C1_PT, C1_KEY, C1_CT, "c1", 1'b0, '0, -1);
    applyStimulus(B_PT, B_KEY, B_CT, "appb", 1'b1, B_RK1, -1);
    applyStimulus(128'h0, 128'h0, Z_CT, "zero", 1'b0, '0, -1);

    // Start held high: blocks every 11 cycles, separate pulses, dataout steady between
    start = 1'b1;
    datain = C1_PT;
    key = C1_KEY;
    done_cnt = 0; first_done = -1; last_done = -1; merged = 0; dout_bad = 0;
    prev_done = 1'b0;
    prev_dout = dataout;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = i;
        last_done = i;
        if (prev_done) merged++;
      end else if (dataout !== prev_dout) begin
        dout_bad++;
      end
      prev_done = done;
      prev_dout = dataout;
    end
    start = 1'b0;
    checkOutput("cont_done_count", done_cnt, 3);
    checkOutput("cont_first_done", first_done, 11);
    checkOutput("cont_last_done", last_done, 33);
    checkOutput("cont_merged", merged, 0);
    checkOutput("cont_dout_unstable", dout_bad, 0);
    checkOutput("cont_dataout", dataout, C1_CT);
    @(negedge clk);
    checkOutput("cont_idle_after", busy, 1'b0);

    applyStimulus(B_PT, B_KEY, B_CT, "glitch", 1'b0, '0, 5);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    checkOutput("glitch_extra_done", extra_done, 0);
    checkOutput("glitch_hold_dataout", dataout, B_CT);

    // Reset while round 6 is pending
    start = 1'b1;
    datain = C1_PT;
    key = C1_KEY;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_dataout", dataout, 128'h0);
    checkOutput("rst_mid_busy", busy, 1'b0);
    checkOutput("rst_mid_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) extra_done++;
    end
    checkOutput("rst_stale_activity", extra_done, 0);
    applyStimulus(B_PT, B_KEY, B_CT, "after_rst", 1'b0, '0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
